// File: rtl/rr_select_stage.sv
// Registered round-robin arbiter feeding the one-hot OR-selector.
// Optional grant lock: define RR_SELECT_STAGE_LOCK_EN to add lock_in.
module rr_select_stage #(
    parameter  int REQ_NUM    = 5,
    parameter  int DATA_WIDTH = 32,
    localparam int IDW        = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REQ_NUM-1:0]    req_valid,
    input  logic [DATA_WIDTH-1:0] req_data [0:REQ_NUM-1],
    output logic [REQ_NUM-1:0]    req_ack,
    output logic [REQ_NUM-1:0]    sel_out,
    output logic [DATA_WIDTH-1:0] data_out [0:REQ_NUM-1],
    output logic [IDW-1:0]        grant_id,
    output logic                  out_valid,
`ifdef RR_SELECT_STAGE_LOCK_EN
    input  logic                  lock_in,
`endif
    input  logic                  out_ready
);

    logic [IDW-1:0]     ptr;
    logic               load_en;
    logic               accept;
    logic               rr_found;
    logic [IDW-1:0]     rr_id;
    logic               lock_hit;
    logic [IDW-1:0]     lock_id;
    logic               win_found;
    logic [IDW-1:0]     win_id;
    logic [REQ_NUM-1:0] win_oh;

    assign load_en = !out_valid | out_ready;
    assign accept  = out_valid & out_ready;

    always_comb begin : rr_scan
        int             idx;
        logic [IDW-1:0] idx_w;
        rr_found = 1'b0;
        rr_id    = '0;
        idx      = 0;
        idx_w    = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            idx = int'(ptr) + k;
            if (idx >= REQ_NUM) idx = idx - REQ_NUM;
            idx_w = IDW'(idx);
            if (!rr_found && req_valid[idx_w]) begin
                rr_found = 1'b1;
                rr_id    = idx_w;
            end
        end
    end

`ifdef RR_SELECT_STAGE_LOCK_EN
    logic           lock_q;
    logic [IDW-1:0] lock_id_q;
    logic           lock_now;

    // An acceptance with lock_in set re-arms the lock on the same edge.
    assign lock_now = accept ? lock_in : lock_q;
    assign lock_id  = accept ? grant_id : lock_id_q;
    assign lock_hit = lock_now & req_valid[lock_id];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else begin
            if (accept) begin
                lock_q    <= lock_in;
                lock_id_q <= grant_id;
            end
            if (lock_now && !req_valid[lock_id]) lock_q <= 1'b0;
        end
    end
`else
    assign lock_hit = 1'b0;
    assign lock_id  = '0;
`endif

    assign win_found = lock_hit | rr_found;
    assign win_id    = lock_hit ? lock_id : rr_id;

    always_comb begin
        win_oh = '0;
        for (int i = 0; i < REQ_NUM; i++)
            win_oh[i] = win_found && (win_id == IDW'(i));
    end

    assign req_ack = (rst || !load_en) ? '0 : win_oh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sel_out   <= '0;
            grant_id  <= '0;
            ptr       <= '0;
            for (int i = 0; i < REQ_NUM; i++) data_out[i] <= '0;
        end else if (load_en) begin
            unique case (1'b1)
                win_found: begin
                    out_valid <= 1'b1;
                    sel_out   <= win_oh;
                    grant_id  <= win_id;
                    for (int i = 0; i < REQ_NUM; i++)
                        data_out[i] <= win_oh[i] ? req_data[i] : '0;
                    if (!lock_hit)
                        ptr <= (win_id == IDW'(REQ_NUM - 1)) ? '0
                                                             : win_id + IDW'(1);
                end
                default: begin
                    out_valid <= 1'b0;
                    sel_out   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_select_stage.sv
// Randomized bench for rr_select_stage against a rotating-priority model.
// Directed lock checks are compiled in when RR_SELECT_STAGE_LOCK_EN is set.
module tb_rr_select_stage;

    localparam int N  = 5;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [DW-1:0] req_data [0:N-1];
    logic [N-1:0]  req_ack;
    logic [N-1:0]  sel_out;
    logic [DW-1:0] data_out [0:N-1];
    logic [2:0]    grant_id;
    logic          out_valid;
    logic          out_ready = 1'b0;
`ifdef RR_SELECT_STAGE_LOCK_EN
    logic          lock_in = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // reference state
    bit      m_valid;
    int      m_gid;
    int      m_ptr;
    bit [7:0] m_data [N];

    always #5 clk = ~clk;

    rr_select_stage #(.REQ_NUM(N), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .sel_out   (sel_out),
        .data_out  (data_out),
        .grant_id  (grant_id),
        .out_valid (out_valid),
`ifdef RR_SELECT_STAGE_LOCK_EN
        .lock_in   (lock_in),
`endif
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] pack_dut();
        logic [39:0] p;
        for (int i = 0; i < N; i++) p[i*8 +: 8] = data_out[i];
        return p;
    endfunction

    function automatic logic [39:0] pack_model();
        logic [39:0] p;
        for (int i = 0; i < N; i++) p[i*8 +: 8] = m_data[i];
        return p;
    endfunction

    // first requester at or after the pointer in circular order
    function automatic int pick(input logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_gid   = 0;
        m_ptr   = 0;
        for (int i = 0; i < N; i++) m_data[i] = 8'h00;
    endtask

    task automatic check_outputs();
        chk("out_valid", out_valid, m_valid);
        chk("sel_out", sel_out, m_valid ? (64'd1 << m_gid) : 64'd0);
        chk("grant_id", grant_id, m_gid);
        chk("data_out", pack_dut(), pack_model());
    endtask

    // called on a falling edge; returns on the next falling edge
    task automatic step(input logic [N-1:0] v, input logic rdy);
        bit          load;
        int          w;
        logic [N-1:0] exp_ack;
        logic [7:0]  d [N];
        req_valid = v;
        out_ready = rdy;
        #1;
        load    = !m_valid || rdy;
        w       = pick(v);
        exp_ack = (load && w >= 0) ? N'(1 << w) : '0;
        chk("req_ack", req_ack, exp_ack);
        for (int i = 0; i < N; i++) d[i] = req_data[i];
        @(posedge clk);
        if (load) begin
            if (w >= 0) begin
                m_valid = 1;
                m_gid   = w;
                for (int i = 0; i < N; i++) m_data[i] = (i == w) ? d[i] : 8'h00;
                m_ptr = (w + 1) % N;
            end else begin
                m_valid = 0;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    logic [N-1:0] exp_seq [6];
    logic [39:0]  pk;

    initial begin
        for (int i = 0; i < N; i++) req_data[i] = '0;
        model_reset();
        repeat (2) @(negedge clk);
        req_valid = '1;
        #1;
        chk("ack_in_rst", req_ack, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_sel", sel_out, 0);
        chk("rst_data", pack_dut(), 0);
        chk("rst_gid", grant_id, 0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;

        for (int c = 0; c < 10; c++) step('0, 1'b1);

        for (int i = 0; i < N; i++) req_data[i] = 8'h10 + 8'(i);
        exp_seq = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
        for (int c = 0; c < 6; c++) begin
            step('1, 1'b1);
            chk("rr_seq", sel_out, exp_seq[c]);
            pk = pack_dut();
            chk("rr_data", pk[(c % N)*8 +: 8], 8'h10 + 8'(c % N));
        end

        req_data[2] = 8'hA5;
        step('1, 1'b1);
        step('1, 1'b1);
        chk("stall_pre", sel_out, 5'b00100);
        for (int c = 0; c < 4; c++) begin
            step('1, 1'b0);
            chk("stall_sel", sel_out, 5'b00100);
            pk = pack_dut();
            chk("stall_data", pk[23:16], 8'hA5);
        end
        step('1, 1'b1);
        chk("stall_next", sel_out, 5'b01000);

        exp_seq[0] = 5'b00001;
        exp_seq[1] = 5'b00010;
        exp_seq[2] = 5'b00001;
        for (int c = 0; c < 3; c++) begin
            step(5'b00011, 1'b1);
            chk("wrap_sel", sel_out, exp_seq[c]);
        end

        #2 rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_sel", sel_out, 0);
        chk("arst_ack", req_ack, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step('1, 1'b1);
        chk("arst_first", sel_out, 5'b00001);

        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] v;
            for (int i = 0; i < N; i++) req_data[i] = 8'($urandom);
            v = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            step(v, $urandom_range(0, 3) != 0);
        end

`ifdef RR_SELECT_STAGE_LOCK_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_valid = '1;
        out_ready = 1'b1;
        exp_seq = '{5'b00001, 5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b00100};
        for (int c = 0; c < 6; c++) begin
            lock_in = (c >= 2 && c <= 4);
            @(posedge clk);
            @(negedge clk);
            chk("lock_sel", sel_out, exp_seq[c]);
        end
        lock_in = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rr_select_stage.md
Name: rr_select_stage

Overview:
- Registered round-robin arbitration stage sitting directly upstream of the one-hot OR-selector used on the bypass/issue paths.
- Picks one of REQ_NUM valid requesters per accepted cycle and registers a one-hot select vector plus a per-slot data array.
- Non-granted slots in the data array are zeroed, so the downstream OR-selector yields the winner's data exactly.
- Provides valid/ready buffering between requesters and the consumer.

Parameters:
- REQ_NUM, 5, number of requesters; width of the one-hot select; must be ≥1.
- DATA_WIDTH, 32, payload width per requester.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  REQ_NUM  per-requester request.
- req_data  input  DATA_WIDTH x [0:REQ_NUM-1]  per-requester payload.
- req_ack  output  REQ_NUM  combinational one-hot acceptance of the winning requester this cycle.
- sel_out  output  REQ_NUM  registered one-hot grant; feeds the selector's sel_in.
- data_out  output  DATA_WIDTH x [0:REQ_NUM-1]  registered payload array; only the granted slot is non-zero.
- grant_id  output  $clog2(REQ_NUM) (min 1)  registered binary index of the granted slot.
- out_valid  output  1  registered entry valid.
- out_ready  input  1  consumer accepts the entry.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - out_valid=0, sel_out=0, all data_out slots=0, grant_id=0, round-robin pointer ptr=0.
  - req_ack=0 while rst is asserted.
- Slot free: load_en = !out_valid | out_ready.
- Winner selection (combinational):
  - Scan req_valid starting at index ptr, ascending, wrapping REQ_NUM-1→0.
  - The first set bit wins; this is a single winner and never multi-hot.
- req_ack[w] = load_en & |req_valid, asserted only for the winner w.
- On a clock edge where load_en=1 and some requester is valid:
  - sel_out <= onehot(w); grant_id <= w.
  - data_out[w] <= req_data[w]; all other slots <= 0.
  - out_valid <= 1.
  - ptr <= (w==REQ_NUM-1) ? 0 : w+1.
- On a clock edge where load_en=1 and no requester is valid:
  - out_valid <= 0 and sel_out <= 0.
  - data_out and grant_id hold; ptr holds.
- On a clock edge where load_en=0: all registers hold (stall). The entry stays stable until accepted.
- Latency: request to out_valid is 1 cycle. Throughput is 1 grant/cycle when out_ready is held high.
- A withdrawn request (req_valid dropping before ack) is legal. It loses arbitration with no side effects.
- out_valid=1 and out_ready=1 with new requests present: the old entry is consumed and the new one is loaded on the same edge (back-to-back).
- REQ_NUM=1: ptr stays 0, and sel_out equals out_valid.
- Invariant: sel_out is zero or one-hot, and sel_out!=0 exactly when out_valid=1.

Optional Feature:
- Macro: RR_SELECT_STAGE_LOCK_EN.
- Defined:
  - Adds input port lock_in (1 bit).
  - If lock_in=1 on an edge where an entry with grant g is accepted (out_valid & out_ready), arbitration on the following cycles forces winner g while req_valid[g]=1, regardless of ptr. ptr is not advanced during locked grants.
  - The lock releases when lock_in=0 at an acceptance, or when req_valid[g]=0; normal round-robin then resumes from the stored ptr.
  - Lock state is cleared by rst.
- Undefined: the lock_in port is absent, and behaviour is pure round-robin as above.

Test Plan (REQ_NUM=5, DATA_WIDTH=8):
- Reset then idle: req_valid=0 → out_valid=0, sel_out=5'b00000, data_out all 0, req_ack=0 for 10 cycles.
- Round-robin fairness: req_valid=5'b11111, req_data[i]=8'h10+i, out_ready=1 → sel_out sequence 00001,00010,00100,01000,10000,00001; data_out granted slot = 8'h10..8'h14; all other slots 0.
- Stall: grant slot 2 (data 8'hA5), out_ready=0 for 4 cycles with req_valid=5'b11111 → sel_out=00100 held, req_ack=0, ptr unchanged; after out_ready=1 the next grant is slot 3.
- Wrap/skip: ptr=4, req_valid=5'b00011 → winner slot 0, then slot 1, then slot 0 again; req_ack matches winner each load cycle.
- Async reset mid-stream: assert rst between edges while out_valid=1 → out_valid and sel_out drop immediately; after release, first grant with req_valid=5'b11111 is slot 0.
- Lock (macro defined): grant slot 1 accepted with lock_in=1, req_valid=5'b11111 → next three grants slot 1; lock_in=0 at acceptance → following grant slot 2.
